// File: rtl/fpu_pkg.sv
// Shared FP32 types and helpers for the fpu reduction logic.
//   fp32_t      : packed IEEE-754 single (sign / exp[7:0] / man[22:0])
//   FP32_QNAN   : canonical quiet NaN returned for NaN results
//   is_nan()    : true for any NaN encoding (quiet or signalling)
//   red_state_e : reduction FSM states
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } red_state_e;

  function automatic logic is_nan(input fp32_t x);
    return (x.exp == 8'hFF) && (x.man != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict a > b for FP32 under a total order on non-NaN values:
// negatives order by reversed magnitude, +0 > -0, denormals by raw bits,
// infinities are ordinary extremes. o_gt is 0 whenever either operand is NaN.
//   i_a, i_b  : FP32 operands
//   o_gt      : a > b (both non-NaN)
//   o_a_nan   : a is NaN
//   o_b_nan   : b is NaN
module fp32_gt
  import fpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_gt,
  output logic        o_a_nan,
  output logic        o_b_nan
);

  logic [31:0] w_key_a;
  logic [31:0] w_key_b;

  // Map each value to an unsigned key whose integer order matches the FP order:
  // negatives invert every bit, positives just set the top bit (so +0 > -0).
  always_comb begin
    w_key_a = i_a[31] ? ~i_a : {1'b1, i_a[30:0]};
    w_key_b = i_b[31] ? ~i_b : {1'b1, i_b[30:0]};
    o_a_nan = is_nan(fp32_t'(i_a));
    o_b_nan = is_nan(fp32_t'(i_b));
    o_gt    = !o_a_nan && !o_b_nan && (w_key_a > w_key_b);
  end

endmodule

// File: rtl/fp_max_reduce.sv
// Streaming FP32 max / argmax reduction over valid/ready packets.
// One result beat per packet carrying the maximum, its earliest index, the
// element count minus one and a sticky overflow flag.
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready/in_data/in_last : input stream
//   out_valid/out_ready             : result handshake
//   out_data/out_idx/out_count/out_ovf : result fields
// Build option FP_MAX_REDUCE_NAN_PROP_EN: when defined any NaN makes the
// result canonical qNaN at the first NaN's index; otherwise NaNs are skipped.
module fp_max_reduce
  import fpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  red_state_e       r_state, w_state_d;
  logic [31:0]      r_acc, w_acc_d;
  logic [CNT_W-1:0] r_idx, w_idx_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_ovf, w_ovf_d;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_gt;
  logic             w_a_nan;
  logic             w_b_nan;
  logic             w_take;
  logic [31:0]      w_take_data;
  logic [31:0]      w_first_data;
  logic [CNT_W-1:0] w_cnt_inc;

  fp32_gt u_gt (
    .i_a     (in_data),
    .i_b     (r_acc),
    .o_gt    (w_gt),
    .o_a_nan (w_a_nan),
    .o_b_nan (w_b_nan)
  );

  assign w_in_fire    = in_valid && r_in_ready;
  assign w_out_fire   = r_out_valid && out_ready;
  assign w_cnt_inc    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  // A NaN accumulator is always stored canonical, so it doubles as the
  // "NaN seen" (prop) or "nothing valid yet" (skip) marker.
  assign w_first_data = w_a_nan ? FP32_QNAN : in_data;

`ifdef FP_MAX_REDUCE_NAN_PROP_EN
  // First NaN wins and sticks; nothing replaces a NaN accumulator.
  assign w_take      = !w_b_nan && (w_a_nan || w_gt);
  assign w_take_data = w_a_nan ? FP32_QNAN : in_data;
`else
  // NaN beats are skipped; any real value replaces a NaN accumulator.
  assign w_take      = !w_a_nan && (w_b_nan || w_gt);
  assign w_take_data = in_data;
`endif

  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_acc_d   = w_first_data;
          w_idx_d   = '0;
          w_cnt_d   = '0;
          w_ovf_d   = 1'b0;
          w_state_d = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (w_in_fire) begin
          if (&r_cnt) begin
            // Saturated: beats past 2**CNT_W only flag overflow.
            w_ovf_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
            if (w_take) begin
              w_acc_d = w_take_data;
              w_idx_d = w_cnt_inc;
            end
          end
          if (in_last) w_state_d = HOLD;
        end
      end
      HOLD: begin
        if (w_out_fire) begin
          w_state_d = IDLE;
          w_ovf_d   = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_idx       <= w_idx_d;
      r_cnt       <= w_cnt_d;
      r_ovf       <= w_ovf_d;
      r_in_ready  <= (w_state_d != HOLD);
      r_out_valid <= (w_state_d == HOLD);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_idx   = r_idx;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_fp_max_reduce.sv
// Self-checking bench for fp_max_reduce: a wide instance (CNT_W=16) and a
// narrow one (CNT_W=2) for saturation. Expected results come from a model that
// orders values by their real-number value (+0 above -0).
module tb_fp_max_reduce;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [31:0] b_in_data, b_out_data;
  logic [15:0] b_out_idx, b_out_count;
  logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_ovf;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_out_idx, s_out_count;

  fp_max_reduce #(.CNT_W(16)) u_dut_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_idx(b_out_idx),
    .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  fp_max_reduce #(.CNT_W(2)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_idx(s_out_idx),
    .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  bit          cur_sel;  // 0: wide instance, 1: narrow instance
  logic        m_in_ready, m_out_valid, m_out_ovf;
  logic [31:0] m_out_data, m_out_idx, m_out_count;

  always_comb begin
    m_in_ready  = cur_sel ? s_in_ready  : b_in_ready;
    m_out_valid = cur_sel ? s_out_valid : b_out_valid;
    m_out_ovf   = cur_sel ? s_out_ovf   : b_out_ovf;
    m_out_data  = cur_sel ? s_out_data  : b_out_data;
    m_out_idx   = cur_sel ? 32'(s_out_idx)   : 32'(b_out_idx);
    m_out_count = cur_sel ? 32'(s_out_count) : 32'(b_out_count);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_data, last_idx, last_cnt, last_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [31:0] d, input logic l);
    if (sel) begin
      s_in_valid = v; s_in_data = d; s_in_last = l;
    end else begin
      b_in_valid = v; b_in_data = d; b_in_last = l;
    end
  endtask

  task automatic set_out_ready(input bit sel, input logic v);
    if (sel) s_out_ready = v;
    else     b_out_ready = v;
  endtask

  function automatic bit nan_ref(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real fp_real(input logic [31:0] x);
    real mag;
    int  e;
    e = int'(x[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else             mag = real'({1'b1, x[22:0]}) * (2.0 ** (e - 150));
    return x[31] ? -mag : mag;
  endfunction

  function automatic bit gt_ref(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = fp_real(a);
    rb = fp_real(b);
    return (ra > rb) || (ra == rb && ra == 0.0 && !a[31] && b[31]);
  endfunction

  // Only the first cap elements contribute; later ones just flag overflow.
  task automatic ref_model(input logic [31:0] pkt[$], input int cap, output logic [31:0] d,
                           output logic [31:0] idx, output logic [31:0] cnt,
                           output logic [31:0] ovf);
    int n;
    bit found;
    bit nan_hit;
    n = (pkt.size() < cap) ? pkt.size() : cap;
    cnt = 32'(n - 1);
    ovf = (pkt.size() > cap) ? 32'd1 : 32'd0;
    d = QNAN;
    idx = 0;
    found = 0;
    nan_hit = 0;
`ifdef FP_MAX_REDUCE_NAN_PROP_EN
    for (int i = 0; i < n; i++) begin
      if (!nan_hit && nan_ref(pkt[i])) begin
        nan_hit = 1;
        idx = 32'(i);
      end
    end
`endif
    if (!nan_hit) begin
      for (int i = 0; i < n; i++) begin
        if (!nan_ref(pkt[i]) && (!found || gt_ref(pkt[i], d))) begin
          d = pkt[i];
          idx = 32'(i);
          found = 1;
        end
      end
    end
  endtask

  task automatic run_pkt(input bit sel, input logic [31:0] pkt[$], input int bp);
    logic [31:0] ed, ei, ec, eo;
    ref_model(pkt, sel ? 4 : 65536, ed, ei, ec, eo);
    cur_sel = sel;
    for (int i = 0; i < pkt.size(); i++) begin
      int guard;
      @(negedge clk);
      drive(sel, 1'b1, pkt[i], i == pkt.size() - 1);
      guard = 0;
      while (!m_in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 32'(m_in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(sel, 1'b0, 32'd0, 1'b0);
    check("out_valid_latency", 32'(m_out_valid), 32'd1);
    for (int k = 0; k < bp; k++) begin
      // Offer a huge value during hold; it must not be accepted.
      drive(sel, 1'b1, 32'h7F7F_FFFF, 1'b1);
      check("hold_in_ready", 32'(m_in_ready), 32'd0);
      check("hold_out_valid", 32'(m_out_valid), 32'd1);
      check("hold_data", m_out_data, ed);
      @(negedge clk);
    end
    drive(sel, 1'b0, 32'd0, 1'b0);
    check("out_data", m_out_data, ed);
    check("out_idx", m_out_idx, ei);
    check("out_count", m_out_count, ec);
    check("out_ovf", 32'(m_out_ovf), eo);
    last_data = m_out_data;
    last_idx  = m_out_idx;
    last_cnt  = m_out_count;
    last_ovf  = 32'(m_out_ovf);
    set_out_ready(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(sel, 1'b0);
    check("out_valid_clear", 32'(m_out_valid), 32'd0);
    check("in_ready_return", 32'(m_in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] pool[3];
    pool[0] = 32'h3F80_0000;
    pool[1] = 32'h4000_0000;
    pool[2] = 32'hC000_0000;
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      5: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      6: return pool[$urandom_range(0, 2)];
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] pkt[$];
    int n;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    set_out_ready(1'b0, 1'b0);
    set_out_ready(1'b1, 1'b0);
    cur_sel = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(m_in_ready), 32'd1);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_out_data", m_out_data, 32'd0);
    check("rst_out_idx", m_out_idx, 32'd0);
    check("rst_out_count", m_out_count, 32'd0);
    check("rst_out_ovf", 32'(m_out_ovf), 32'd0);
    rst_n = 1'b1;

    pkt = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000};
    run_pkt(1'b0, pkt, 0);
    check("t1_data", last_data, 32'h4040_0000);
    check("t1_idx", last_idx, 32'd1);
    check("t1_count", last_cnt, 32'd2);

    pkt = '{32'h4000_0000, 32'h4000_0000};
    run_pkt(1'b0, pkt, 0);
    check("tie_idx", last_idx, 32'd0);
    pkt = '{32'h8000_0000, 32'h0000_0000};
    run_pkt(1'b0, pkt, 0);
    check("zero_data", last_data, 32'h0000_0000);
    check("zero_idx", last_idx, 32'd1);

    pkt = '{32'hC000_0000, 32'hBF80_0000, 32'hC040_0000};
    run_pkt(1'b0, pkt, 0);
    check("neg_data", last_data, 32'hBF80_0000);
    check("neg_idx", last_idx, 32'd1);
    pkt = '{32'h4120_0000};
    run_pkt(1'b0, pkt, 0);
    check("single_idx", last_idx, 32'd0);
    check("single_count", last_cnt, 32'd0);

    pkt = '{32'h3F00_0000, 32'h4100_0000, 32'h3F00_0000};
    run_pkt(1'b0, pkt, 5);

    pkt = '{32'h3F80_0000, 32'h7FC0_0001, 32'h4000_0000};
    run_pkt(1'b0, pkt, 0);
`ifdef FP_MAX_REDUCE_NAN_PROP_EN
    check("nan_data", last_data, 32'h7FC0_0000);
    check("nan_idx", last_idx, 32'd1);
`else
    check("nan_data", last_data, 32'h4000_0000);
    check("nan_idx", last_idx, 32'd2);
`endif

    pkt = '{32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F00_0000,
            32'h3E80_0000, 32'h3F80_0000};
    run_pkt(1'b1, pkt, 0);
    check("ovf_flag", last_ovf, 32'd1);
    check("ovf_count", last_cnt, 32'd3);
    check("ovf_data", last_data, 32'h4040_0000);

    // Abort a packet with reset; no result may appear.
    cur_sel = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h4100_0000, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("rst_mid_no_out", 32'(m_out_valid), 32'd0);
      @(negedge clk);
    end
    pkt = '{32'hBF80_0000, 32'h3F80_0000};
    run_pkt(1'b1, pkt, 0);
    check("post_rst_data", last_data, 32'h3F80_0000);
    check("post_rst_idx", last_idx, 32'd1);

    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pkt.push_back(rnd_fp());
      run_pkt(1'b0, pkt, $urandom_range(0, 3));
    end
    for (int p = 0; p < 15; p++) begin
      pkt.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) pkt.push_back(rnd_fp());
      run_pkt(1'b1, pkt, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
